seq_playback_ctrl: RTL and testbench
====================================

SEQ_PLAYBACK_CTRL -- requirements
Module: seq_playback_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- TILE_SIZE, 8: tile edge in pixels; fixed at 8, since the pixel counter is 6 bits.
- HOLD_CYCLES, 25000000: number of cycles a drawn tile stays lit.
- GAP_CYCLES, 12500000: number of blank cycles between tiles.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: single clock.
- resetn, in, 1: asynchronous, active-low reset.
- start, in, 1: begin playback; sampled only in IDLE.
- abort, in, 1: synchronous cancel.
- level, in, 4: number of tiles to play, 0..15.
- tile_x, in, 8: tile origin x, from the tile LUT.
- tile_y, in, 8: tile origin y, from the tile LUT.
- tile_colour, in, 3: tile colour, from the tile LUT.
- lut_counter, out, 6: sequence index driven to the tile LUT.
- lut_load_random, out, 1: selects sequence mode in the tile LUT.
- vga_x, out, 8: plot x coordinate.
- vga_y, out, 8: plot y coordinate.
- vga_colour, out, 3: plot colour.
- plot, out, 1: pixel write strobe.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle completion pulse.
REQ-003 Clocking and reset SHALL be one clock, with reset asynchronous and active-low (clock, resetn).

Function
REQ-004 The FSM SHALL have these states: IDLE, DRAW, HOLD, ERASE, GAP, NEXT, DONE.
REQ-005 In IDLE, start=1 SHALL move the FSM to DRAW on the next edge, with lut_counter=0.
- If the effective level is 0, the FSM SHALL go to DONE instead.
REQ-006 The effective level SHALL be min(level, 9).
- level is latched at start.
- Later changes to level SHALL be ignored until the next start.
REQ-007 DRAW SHALL last exactly 64 cycles, with plot=1 on every cycle.
- A 6-bit pixel counter pix runs 0..63.
- vga_x = tile_x + pix[2:0], vga_y = tile_y + pix[5:3], both 8-bit with wrap.
- vga_colour = tile_colour.
REQ-008 HOLD SHALL last exactly HOLD_CYCLES cycles with plot=0.
REQ-009 ERASE SHALL last exactly 64 cycles with the same coordinate rule as DRAW, vga_colour=3'b000 and plot=1.
REQ-010 GAP SHALL last exactly GAP_CYCLES cycles with plot=0.
REQ-011 NEXT SHALL last one cycle.
- If lut_counter == effective_level-1, the FSM SHALL go to DONE.
- Otherwise lut_counter SHALL increment and the FSM SHALL go to DRAW.
REQ-012 DONE SHALL last one cycle with done=1, then return to IDLE with lut_counter reset to 0.
REQ-013 Per-tile time SHALL be 129+HOLD_CYCLES+GAP_CYCLES cycles.
- With start accepted at cycle 0, done SHALL rise at cycle 1+N*(129+HOLD_CYCLES+GAP_CYCLES).
REQ-014 start SHALL be ignored while busy=1.
REQ-015 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
- In that cycle plot=0, done=0 and lut_counter=0.
- abort SHALL win over a simultaneous start or DONE.
REQ-016 lut_load_random SHALL equal busy.
REQ-017 In IDLE and DONE, plot=0 and vga_x, vga_y, vga_colour SHALL be 0.
REQ-018 HOLD_CYCLES=0 or GAP_CYCLES=0 SHALL skip that state in zero cycles.

Reset
REQ-019 resetn=0 SHALL immediately force state IDLE and set every output to 0.
- This covers lut_counter, vga_x/y/colour, plot, busy, done, lut_load_random and all internal counters, regardless of the clock.
REQ-020 Reset asserted mid-operation SHALL discard the playback; no done pulse SHALL follow release.

Structure
REQ-021 A shared package (simon_pkg) SHALL hold:
- the state encoding;
- TILE_SIZE;
- MAX_LEVEL=9;
- COLOUR_BLACK=3'b000.
REQ-022 A sub-module delay_timer SHALL implement HOLD/GAP timing.
- Ports: load, terminal count, expired flag.
- It SHALL be sized by $clog2 of the larger of HOLD_CYCLES and GAP_CYCLES.

Verification
Bench: HOLD_CYCLES=4, GAP_CYCLES=2 (tile period 135), with the tile LUT in the loop.
REQ-023 level=1, seq[1:0]=2'b10 (LUT index 01), start at cycle 0 -> cycles 1-64: plot at x 8..15, y 0..7, colour 010; cycles 69-132: same pixels, colour 000; done=1 at cycle 136 only.
REQ-024 level=3, start at cycle 0 -> lut_counter steps 0,1,2 with 128 plot cycles per tile; done=1 at cycle 406.
REQ-025 level=0 -> done=1 at cycle 1 with no plot; level=12 -> exactly 9 tiles, done=1 at cycle 1216.
REQ-026 start pulsed at cycle 30 during a playback -> no effect; abort at cycle 66 (HOLD) -> IDLE at cycle 67, busy=0, no done.
REQ-027 resetn dropped mid-DRAW at cycle 20 -> plot, busy, vga_* = 0 before the next edge; after release, start -> normal playback from lut_counter=0.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding and constants for tile sequence playback
package simon_pkg;
  typedef enum logic [2:0] {IDLE, DRAW, HOLD, ERASE, GAP, NEXT, DONE} state_t;
  localparam int TILE_SIZE = 8;
  localparam logic [3:0] MAX_LEVEL = 4'd9;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;
endpackage

// File: rtl/delay_timer.sv
// delay_timer: loadable down-counter whose expired flag marks the last cycle of a delay
module delay_timer #(
  parameter int MAX_CYCLES = 2,
  parameter int W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] tc,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (load) cnt <= tc;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/seq_playback_ctrl.sv
// seq_playback_ctrl: plays a tile sequence by drawing, holding, erasing and gapping each tile
module seq_playback_ctrl
  import simon_pkg::*;
#(
  parameter int TILE_SIZE   = 8,
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] level,
  input  logic [7:0] tile_x,
  input  logic [7:0] tile_y,
  input  logic [2:0] tile_colour,
  output logic [5:0] lut_counter,
  output logic       lut_load_random,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [5:0] PIX_LAST = 6'(TILE_SIZE * TILE_SIZE - 1);
  // timer is loaded with N-1 so its state lasts exactly N cycles
  localparam logic [TW-1:0] HOLD_TC = TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [TW-1:0] GAP_TC = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  state_t state, nxt;
  logic [5:0] pix, cnt;
  logic [3:0] lvl;
  logic [TW-1:0] tc;
  logic load, expired, pixel, last_pix;
  delay_timer #(.MAX_CYCLES(MAXC), .W(TW)) u_timer (
    .clock(clock), .resetn(resetn), .load(load), .tc(tc), .expired(expired)
  );
  assign pixel = state == DRAW || state == ERASE;
  assign last_pix = pix == PIX_LAST;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      pix <= '0;
      cnt <= '0;
      lvl <= '0;
    end else begin
      state <= nxt;
      pix <= (pixel && !abort) ? pix + 6'd1 : 6'd0;
      if (state == IDLE && start) lvl <= (level > MAX_LEVEL) ? MAX_LEVEL : level;
      cnt <= (state == NEXT && nxt == DRAW) ? cnt + 6'd1 : (nxt == IDLE) ? 6'd0 : cnt;
    end
  always_comb begin
    nxt = state;
    load = 1'b0;
    tc = HOLD_TC;
    case (state)
      IDLE: if (start) nxt = (level == 4'd0) ? DONE : DRAW;
      DRAW: if (last_pix) begin
        nxt = (HOLD_CYCLES == 0) ? ERASE : HOLD;
        load = 1'b1;
      end
      HOLD: if (expired) nxt = ERASE;
      ERASE: if (last_pix) begin
        nxt = (GAP_CYCLES == 0) ? NEXT : GAP;
        load = 1'b1;
        tc = GAP_TC;
      end
      GAP: if (expired) nxt = NEXT;
      NEXT: nxt = (cnt == {2'b00, lvl - 4'd1}) ? DONE : DRAW;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end
  assign busy = state != IDLE;
  assign lut_load_random = busy;
  assign plot = pixel && !abort;
  assign done = state == DONE && !abort;
  assign lut_counter = abort ? 6'd0 : cnt;
  assign vga_x = pixel ? tile_x + {5'b0, pix[2:0]} : 8'd0;
  assign vga_y = pixel ? tile_y + {5'b0, pix[5:3]} : 8'd0;
  assign vga_colour = (state == DRAW) ? tile_colour : COLOUR_BLACK;
endmodule

// File: tb/tb_seq_playback_ctrl.sv
// tb_seq_playback_ctrl: directed checks of playback timing, pixels, abort and reset
module tb_seq_playback_ctrl;
  logic clock = 0, resetn = 0, start = 0, abort = 0;
  logic [3:0] level = 0;
  logic [7:0] tile_x, tile_y, vga_x, vga_y;
  logic [2:0] tile_colour, vga_colour;
  logic [5:0] lut_counter;
  logic lut_load_random, plot, busy, done;
  logic [1:0] idx;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] pl [0:1300], xs [0:1300], ys [0:1300], cs [0:1300], lc [0:1300], bs [0:1300], dn [0:1300];

  seq_playback_ctrl #(.TILE_SIZE(8), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort), .level(level),
    .tile_x(tile_x), .tile_y(tile_y), .tile_colour(tile_colour),
    .lut_counter(lut_counter), .lut_load_random(lut_load_random),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // tile LUT: entry k holds tile index k+1 (mod 4); index bit0 -> x=8, bit1 -> y=8
  always_comb begin
    idx = lut_counter[1:0] + 2'd1;
    tile_x = {4'b0, idx[0], 3'b0};
    tile_y = {4'b0, idx[1], 3'b0};
    tile_colour = {1'b0, idx} + 3'd1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic play(input logic [3:0] lv, input int n, input int start_at, input int abort_at);
    @(negedge clock);
    level = lv;
    start = 1;
    @(posedge clock);
    #1 start = 0;
    level = 4'hF;
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      pl[c] = 8'(plot); xs[c] = vga_x; ys[c] = vga_y; cs[c] = 8'(vga_colour);
      lc[c] = 8'(lut_counter); bs[c] = 8'(busy); dn[c] = 8'(done);
      start = (c == start_at);
      abort = (c == abort_at);
    end
    start = 0;
    abort = 0;
  endtask

  function automatic int plots(input int a, input int b);
    int s = 0;
    for (int c = a; c <= b; c++) s += pl[c];
    return s;
  endfunction

  function automatic int done_at(input int n);
    for (int c = 1; c <= n; c++) if (dn[c] != 0) return c;
    return -1;
  endfunction

  function automatic int done_cnt(input int n);
    int s = 0;
    for (int c = 1; c <= n; c++) s += dn[c];
    return s;
  endfunction

  initial begin
    int d;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_cnt", lut_counter, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clock);
    resetn = 1;

    play(1, 140, -1, -1);
    chk("l1_plot1", pl[1], 1);
    chk("l1_x1", xs[1], 8);
    chk("l1_y1", ys[1], 0);
    chk("l1_col1", cs[1], 2);
    chk("l1_x10", xs[10], 9);
    chk("l1_y10", ys[10], 1);
    chk("l1_x64", xs[64], 15);
    chk("l1_y64", ys[64], 7);
    chk("l1_hold", plots(65, 68), 0);
    chk("l1_erase_plot", pl[69], 1);
    chk("l1_erase_col", cs[69], 0);
    chk("l1_erase_x", xs[69], 8);
    chk("l1_erase_y132", ys[132], 7);
    chk("l1_gap", plots(133, 140), 0);
    chk("l1_plots", plots(1, 140), 128);
    chk("l1_done_at", done_at(140), 136);
    chk("l1_done_n", done_cnt(140), 1);
    chk("l1_idle", bs[137], 0);
    chk("l1_busy", bs[100], 1);

    play(3, 410, -1, -1);
    chk("l3_cnt1", lc[1], 0);
    chk("l3_cnt136", lc[136], 1);
    chk("l3_cnt271", lc[271], 2);
    chk("l3_x136", xs[136], 0);
    chk("l3_y136", ys[136], 8);
    chk("l3_col136", cs[136], 3);
    chk("l3_plots", plots(1, 410), 384);
    chk("l3_done_at", done_at(410), 406);

    play(0, 5, -1, -1);
    chk("l0_done_at", done_at(5), 1);
    chk("l0_plots", plots(1, 5), 0);
    chk("l0_idle", bs[2], 0);

    play(12, 1220, -1, -1);
    chk("l12_done_at", done_at(1220), 1216);
    chk("l12_done_n", done_cnt(1220), 1);
    chk("l12_plots", plots(1, 1220), 9 * 128);

    play(2, 140, 30, 66);
    chk("ab_start_x", xs[31], 14);
    chk("ab_start_y", ys[31], 3);
    chk("ab_busy66", bs[66], 1);
    chk("ab_idle67", bs[67], 0);
    chk("ab_cnt67", lc[67], 0);
    chk("ab_done_n", done_cnt(140), 0);
    chk("ab_plots", plots(1, 140), 64);

    play(2, 20, -1, -1);
    resetn = 0;
    #1;
    chk("mr_plot", plot, 0);
    chk("mr_busy", busy, 0);
    chk("mr_x", vga_x, 0);
    chk("mr_y", vga_y, 0);
    chk("mr_lr", lut_load_random, 0);
    repeat (2) @(negedge clock);
    resetn = 1;
    d = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      d += done + busy;
    end
    chk("mr_quiet", d, 0);
    play(2, 275, -1, -1);
    chk("mr_cnt1", lc[1], 0);
    chk("mr_x1", xs[1], 8);
    chk("mr_done_at", done_at(275), 271);
    chk("mr_plots", plots(1, 275), 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
